// File: rtl/security_pkg.sv
// Shared constants, FSM state type and rotate helper
// for the security block's stream cipher.
package security_pkg;

   localparam int          WORD_W    = 32;
   localparam logic [31:0] LFSR_TAPS = 32'h80200003;
   localparam logic [31:0] LFSR_SEED = 32'h00000001;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      CAPT,
      OUT
   } state_t;

   function automatic logic [WORD_W-1:0] rotl(
      input logic [WORD_W-1:0] v,
      input int unsigned       n
   );
      logic [2*WORD_W-1:0] d;
      d = {v, v} << (n % WORD_W);
      return d[2*WORD_W-1:WORD_W];
   endfunction

endpackage

// File: rtl/keystream_lfsr.sv
// Galois LFSR keystream generator with seed load
// and single-step advance.
module keystream_lfsr
   import security_pkg::*;
#(
   parameter int                W    = WORD_W,
   parameter logic [W-1:0]      TAPS = LFSR_TAPS,
   parameter logic [W-1:0]      SEED = LFSR_SEED
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] seed,
   input  logic         step,
   output logic [W-1:0] value
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= SEED;
      end else if (load) begin
         // an all-zero state would lock the LFSR
         value <= (seed == '0) ? SEED : seed;
      end else if (step) begin
         value <= value[0] ? ((value >> 1) ^ TAPS)
                           : (value >> 1);
      end
   end

endmodule

// File: rtl/fifo_stream_cipher.sv
// FIFO consumer: pops words, XORs with LFSR keystream,
// rotates and presents them on a valid/ready port.
module fifo_stream_cipher
   import security_pkg::*;
#(
   parameter int                DATA_W       = WORD_W,
   parameter int unsigned       ROT          = 5,
   parameter logic [DATA_W-1:0] TAPS         = LFSR_TAPS,
   parameter logic [DATA_W-1:0] DEFAULT_SEED = LFSR_SEED,
   parameter int                CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              key_load,
   input  logic [DATA_W-1:0] key_in,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_rd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic [CNT_W-1:0]  word_cnt
);

   state_t            state;
   logic [DATA_W-1:0] ks;
   logic              ks_load;
   logic              ks_step;

   assign ks_load = key_load && (state == IDLE);
   assign ks_step = (state == CAPT);
   assign busy    = (state != IDLE);

   keystream_lfsr #(
      .W    (DATA_W),
      .TAPS (TAPS),
      .SEED (DEFAULT_SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (ks_load),
      .seed  (key_in),
      .step  (ks_step),
      .value (ks)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         fifo_rd   <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         word_cnt  <= '0;
      end else begin
         fifo_rd <= 1'b0;
         unique case (state)
            IDLE: begin
               // key load wins over a pending FIFO word
               if (!key_load && !fifo_empty) begin
                  fifo_rd <= 1'b1;
                  state   <= WAIT;
               end
            end
            WAIT: begin
               state <= CAPT;
            end
            CAPT: begin
               out_data  <= rotl(fifo_data ^ ks, ROT);
               out_valid <= 1'b1;
               state     <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  word_cnt  <= word_cnt + 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/fifo_stream_cipher.md
Name: fifo_stream_cipher

Overview:
- Downstream consumer of the security block's 32-bit FIFO read port.
- Pops words whenever the FIFO is non-empty, XORs each word with a 32-bit Galois-LFSR keystream and rotates the result left.
- Presents each ciphertext word on a valid/ready output handshake.
- Keeps a count of delivered words.

Parameters:
- DATA_W, 32, word width; must match the FIFO data width.
- ROT, 5, left-rotate amount applied after the XOR (0..DATA_W-1).
- TAPS, 32'h80200003, Galois LFSR feedback mask (x^32+x^22+x^2+x+1).
- DEFAULT_SEED, 32'h00000001, LFSR value after reset, and substitute for an all-zero key.
- CNT_W, 16, width of the delivered-word counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_load  in  1  load key_in as the LFSR seed; honoured in IDLE only.
- key_in  in  DATA_W  seed value.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATA_W  FIFO data_out; valid the cycle after fifo_rd was high.
- fifo_rd  out  1  FIFO read strobe, one-cycle pulse.
- out_valid  out  1  ciphertext word valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_W  ciphertext word.
- busy  out  1  high whenever state != IDLE.
- word_cnt  out  CNT_W  number of words accepted by the consumer.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, lfsr=DEFAULT_SEED, fifo_rd=0, out_valid=0, out_data=0, word_cnt=0, busy=0. Reset mid-operation abandons the word in flight; it is never presented.
- States:
  - IDLE: if key_load=1, load lfsr=key_in, or DEFAULT_SEED if key_in==0. Stay in IDLE that cycle even if the FIFO is non-empty (key has priority). Otherwise, if fifo_empty=0: fifo_rd=1 for exactly one cycle, go to WAIT.
  - WAIT: fifo_rd=0 and the FIFO read completes. Go to CAPT.
  - CAPT: out_data <= rotl(fifo_data ^ lfsr, ROT); out_valid <= 1. Advance lfsr one Galois step: if lfsr[0], lfsr <= (lfsr>>1)^TAPS, else lfsr <= lfsr>>1. Go to OUT.
  - OUT: hold out_valid and out_data stable until out_ready=1. On the accepting edge: out_valid <= 0, word_cnt <= word_cnt+1 (wraps 2^CNT_W-1 -> 0), go to IDLE.
- Latency and throughput:
  - fifo_rd edge to out_valid high is 2 cycles.
  - Best case, with out_ready tied high, is one word every 4 cycles.
- The keystream advances exactly once per word captured. The keystream word used is the LFSR value before advancing.
- key_load outside IDLE is ignored and does not stall; the seed is not altered mid-word.
- fifo_rd is never asserted while fifo_empty=1, and never in WAIT, CAPT or OUT. No back-to-back reads.
- out_ready while out_valid=0 has no effect.
- ROT=0 gives a plain XOR. Rotation is a wrap-around within DATA_W bits.

Decomposition:
- Shared package security_pkg: DATA_W, the TAPS and DEFAULT_SEED constants, the state enum {IDLE, WAIT, CAPT, OUT}, and an rotl function.
- One natural sub-module, keystream_lfsr: seed load, step enable, current value. The FSM, datapath and counter stay in fifo_stream_cipher.

Test Plan:
1. Reset, then FIFO presents 0x0078696E with default seed and out_ready=1 -> fifo_rd pulses once, 2 cycles later out_data=0x0F0D2DE0 with out_valid for 1 cycle, word_cnt=1.
2. Second word 0x6368616F follows (lfsr now 0x80200003) -> out_data=0x690C2D9C, word_cnt=2.
3. Hold out_ready=0 for 5 cycles with FIFO non-empty -> out_data stable, out_valid stays high, no further fifo_rd. Then out_ready=1 -> one word accepted, next fifo_rd issued from IDLE.
4. key_load with key_in=0 in IDLE -> lfsr=0x00000001. key_load with key_in=0xDEADBEEF during OUT -> ignored, next ciphertext still uses the old keystream.
5. fifo_empty=1 for 20 cycles -> fifo_rd never asserted, busy=0. Assert rst_n=0 while in OUT -> out_valid drops immediately, word_cnt=0, lfsr=DEFAULT_SEED.
6. Preload word_cnt to 0xFFFF by streaming, accept one more word -> word_cnt wraps to 0x0000.
